// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit command frames, decodes them and serializes the response.
// Build option: define SD_CMD_CRC_CHECK_EN to reject commands whose received CRC7 does not match.
module sd_card_cmd_responder #(
   parameter int NCR_CYCLES  = 2,
   parameter int RESP_WINDOW = 64
) (
   input  logic        sd_clock,
   input  logic        reset,
   input  logic        cmd_pin_in,
   output logic        cmd_pin_out,
   output logic        cmd_oe,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_argument,
   output logic        frame_error,
   output logic        crc_error,
   input  logic        resp_strobe,
   input  logic        resp_none,
   input  logic [5:0]  resp_index,
   input  logic [31:0] resp_status,
   output logic        resp_timeout,
   output logic        busy
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RECV     = 3'd1;
   localparam logic [2:0] S_CHECK    = 3'd2;
   localparam logic [2:0] S_WAIT_APP = 3'd3;
   localparam logic [2:0] S_NCR_WAIT = 3'd4;
   localparam logic [2:0] S_SEND     = 3'd5;

   localparam logic [7:0] WIN_LAST = 8'(RESP_WINDOW - 1);
   localparam logic [7:0] NCR_MIN  = 8'(NCR_CYCLES);

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   function automatic logic [6:0] crc7_block(input logic [39:0] d);
      logic [6:0] c;
      c = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         c = crc7_step(c, d[i]);
      end
      return c;
   endfunction

   logic [2:0]  state_q, state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [46:0] rx_q, rx_d;
   logic [7:0]  win_q, win_d;
   logic [47:0] tx_q, tx_d;
   logic        pin_q, pin_d;
   logic        oe_q, oe_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        cerr_q, cerr_d;
   logic        tout_q, tout_d;
   logic [5:0]  idx_q, idx_d;
   logic [31:0] arg_q, arg_d;
   logic [6:0]  resp_crc;
`ifdef SD_CMD_CRC_CHECK_EN
   logic [6:0]  rx_crc_q, rx_crc_d;
`else
   logic        crc_field_unused;
   assign crc_field_unused = ^rx_q[7:1];
`endif

   assign resp_crc = crc7_block({2'b00, resp_index, resp_status});

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      pin_d     = pin_q;
      oe_d      = oe_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      cerr_d    = 1'b0;
      tout_d    = 1'b0;
      idx_d     = idx_q;
      arg_d     = arg_q;
`ifdef SD_CMD_CRC_CHECK_EN
      rx_crc_d  = rx_crc_q;
`endif
      // Window counter free-runs (saturating); it is zeroed on the end-bit edge
      win_d = (win_q == 8'hFF) ? win_q : win_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (!cmd_pin_in) begin
               state_d   = S_RECV;
               bit_cnt_d = 6'd1;
`ifdef SD_CMD_CRC_CHECK_EN
               rx_crc_d  = 7'd0;
`endif
            end
         end
         S_RECV: begin
            rx_d      = {rx_q[45:0], cmd_pin_in};
            bit_cnt_d = bit_cnt_q + 6'd1;
`ifdef SD_CMD_CRC_CHECK_EN
            if (bit_cnt_q <= 6'd39) begin
               rx_crc_d = crc7_step(rx_crc_q, cmd_pin_in);
            end
`endif
            if (bit_cnt_q == 6'd47) begin
               state_d = S_CHECK;
               win_d   = 8'd0;
            end
         end
         S_CHECK: begin
            // rx_q[46] is the transmission bit, rx_q[0] the end bit
            if (!rx_q[46] || !rx_q[0]) begin
               ferr_d  = 1'b1;
               state_d = S_IDLE;
            end
`ifdef SD_CMD_CRC_CHECK_EN
            else if (rx_q[7:1] != rx_crc_q) begin
               cerr_d  = 1'b1;
               state_d = S_IDLE;
            end
`endif
            else begin
               valid_d = 1'b1;
               idx_d   = rx_q[45:40];
               arg_d   = rx_q[39:8];
               state_d = S_WAIT_APP;
            end
         end
         S_WAIT_APP: begin
            if (resp_none) begin
               state_d = S_IDLE;
            end else if (resp_strobe) begin
               tx_d    = {2'b00, resp_index, resp_status, resp_crc, 1'b1};
               state_d = S_NCR_WAIT;
            end else if (win_q == WIN_LAST) begin
               tout_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_NCR_WAIT: begin
            if (win_q >= NCR_MIN) begin
               state_d   = S_SEND;
               pin_d     = tx_q[47];
               oe_d      = 1'b1;
               tx_d      = {tx_q[46:0], 1'b1};
               bit_cnt_d = 6'd47;
            end
         end
         S_SEND: begin
            if (bit_cnt_q != 6'd0) begin
               pin_d     = tx_q[47];
               tx_d      = {tx_q[46:0], 1'b1};
               bit_cnt_d = bit_cnt_q - 6'd1;
            end else begin
               pin_d   = 1'b1;
               oe_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sd_clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= 6'd0;
         win_q     <= 8'd0;
         pin_q     <= 1'b1;
         oe_q      <= 1'b0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         cerr_q    <= 1'b0;
         tout_q    <= 1'b0;
         idx_q     <= 6'd0;
         arg_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         win_q     <= win_d;
         pin_q     <= pin_d;
         oe_q      <= oe_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         cerr_q    <= cerr_d;
         tout_q    <= tout_d;
         idx_q     <= idx_d;
         arg_q     <= arg_d;
      end
   end

   // Shift registers carry data only; the FSM decides when they are meaningful
   always_ff @(posedge sd_clock) begin
      rx_q     <= rx_d;
      tx_q     <= tx_d;
`ifdef SD_CMD_CRC_CHECK_EN
      rx_crc_q <= rx_crc_d;
`endif
   end

   assign cmd_pin_out  = pin_q;
   assign cmd_oe       = oe_q;
   assign cmd_valid    = valid_q;
   assign cmd_index    = idx_q;
   assign cmd_argument = arg_q;
   assign frame_error  = ferr_q;
   assign crc_error    = cerr_q;
   assign resp_timeout = tout_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Bench for sd_card_cmd_responder: schedule-based model of expected outputs per clock edge.
module tb_sd_card_cmd_responder;
   localparam int NCR = 2;
   localparam int RW  = 64;
   localparam int ARR = 4096;
   localparam int A_NONE = 0, A_STROBE = 1, A_BOTH = 2, A_SILENT = 3, A_STRAY = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pin_in = 1'b1;
   logic        strobe = 1'b0;
   logic        rnone = 1'b0;
   logic [5:0]  ridx = 6'd0;
   logic [31:0] rstat = 32'd0;
   logic        cmd_pin_out, cmd_oe, cmd_valid, frame_error, crc_error, resp_timeout, busy;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_argument;

   int edge_n = 0;
   int checks = 0;
   int errors = 0;

   bit          e_pin [ARR];
   bit          e_oe [ARR];
   bit          e_busy [ARR];
   bit          e_valid [ARR];
   bit          e_ferr [ARR];
   bit          e_cerr [ARR];
   bit          e_tout [ARR];
   bit          e_rst [ARR];
   logic [5:0]  e_idx [ARR];
   logic [31:0] e_arg [ARR];
   logic [5:0]  held_idx = 6'd0;
   logic [31:0] held_arg = 32'd0;

   logic [47:0] cap = 48'd0;
   int          oe_cnt = 0;
   int          first_oe = -1;
   bit          cap_en = 1'b0;

   sd_card_cmd_responder #(.NCR_CYCLES(NCR), .RESP_WINDOW(RW)) dut (
      .sd_clock(clk), .reset(reset), .cmd_pin_in(pin_in), .cmd_pin_out(cmd_pin_out),
      .cmd_oe(cmd_oe), .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_argument(cmd_argument),
      .frame_error(frame_error), .crc_error(crc_error), .resp_strobe(strobe), .resp_none(rnone),
      .resp_index(ridx), .resp_status(rstat), .resp_timeout(resp_timeout), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   // CRC7 as remainder of M(x)*x^7 divided by x^7+x^3+1
   function automatic logic [6:0] model_crc(input logic [39:0] m);
      logic [46:0] r;
      r = {m, 7'd0};
      for (int i = 46; i >= 7; i--) begin
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      end
      return r[6:0];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_n, act, exp);
      end
   endtask

   task automatic goto_edge(input int e);
      while (edge_n < e) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (edge_n >= 1 && edge_n < ARR) begin
         if (e_rst[edge_n]) begin
            held_idx = 6'd0;
            held_arg = 32'd0;
         end else if (e_valid[edge_n]) begin
            held_idx = e_idx[edge_n];
            held_arg = e_arg[edge_n];
         end
         chk("cmd_pin_out", 64'(cmd_pin_out), 64'(e_pin[edge_n]));
         chk("cmd_oe", 64'(cmd_oe), 64'(e_oe[edge_n]));
         chk("busy", 64'(busy), 64'(e_busy[edge_n]));
         chk("cmd_valid", 64'(cmd_valid), 64'(e_valid[edge_n]));
         chk("frame_error", 64'(frame_error), 64'(e_ferr[edge_n]));
         chk("crc_error", 64'(crc_error), 64'(e_cerr[edge_n]));
         chk("resp_timeout", 64'(resp_timeout), 64'(e_tout[edge_n]));
         chk("cmd_index", 64'(cmd_index), 64'(held_idx));
         chk("cmd_argument", 64'(cmd_argument), 64'(held_arg));
         if (cap_en && cmd_oe) begin
            cap = {cap[46:0], cmd_pin_out};
            if (oe_cnt == 0) first_oe = edge_n;
            oe_cnt++;
         end
      end
   end

   task automatic send_cmd(input logic [47:0] fr, input int act, input int dly,
                           input logic [5:0] ri, input logic [31:0] rs,
                           output int s, output int ts, output int done);
      logic        ok_fr, ok_crc;
      logic [47:0] rf;
      int          t;
      @(negedge clk);
      s = edge_n + 1;
      t = s + 49 + dly;
      ts = -1;
      ok_fr = fr[46] && fr[0];
`ifdef SD_CMD_CRC_CHECK_EN
      ok_crc = (model_crc(fr[47:8]) == fr[7:1]);
`else
      ok_crc = 1'b1;
`endif
      if (!ok_fr) begin
         e_ferr[s + 48] = 1'b1;
         done = s + 48;
      end else if (!ok_crc) begin
         e_cerr[s + 48] = 1'b1;
         done = s + 48;
      end else begin
         e_valid[s + 48] = 1'b1;
         e_idx[s + 48] = fr[45:40];
         e_arg[s + 48] = fr[39:8];
         if (act == A_SILENT || act == A_STRAY) begin
            done = s + 47 + RW;
            e_tout[done] = 1'b1;
         end else if (act == A_STROBE) begin
            ts = (t + 1 > s + 48 + NCR) ? t + 1 : s + 48 + NCR;
            rf = {2'b00, ri, rs, model_crc({2'b00, ri, rs}), 1'b1};
            for (int j = 0; j < 48; j++) begin
               e_pin[ts + j] = rf[47 - j];
               e_oe[ts + j] = 1'b1;
            end
            done = ts + 48;
         end else begin
            done = t;
         end
      end
      for (int e = s; e < done; e++) e_busy[e] = 1'b1;

      for (int k = 0; k < 48; k++) begin
         goto_edge(s + k - 1);
         pin_in = fr[47 - k];
      end
      goto_edge(s + 47);
      pin_in = 1'b1;
      if (act == A_STRAY) begin
         goto_edge(s + 47 + RW);
         strobe = 1'b1;
         goto_edge(s + 48 + RW);
         strobe = 1'b0;
      end else if (act != A_SILENT) begin
         goto_edge(t - 1);
         ridx = ri;
         rstat = rs;
         strobe = (act != A_NONE);
         rnone = (act != A_STROBE);
         goto_edge(t);
         strobe = 1'b0;
         rnone = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete at edge %0d", edge_n);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s, ts, done;
      for (int i = 0; i < ARR; i++) begin
         e_pin[i] = 1'b1; e_oe[i] = 1'b0; e_busy[i] = 1'b0; e_valid[i] = 1'b0;
         e_ferr[i] = 1'b0; e_cerr[i] = 1'b0; e_tout[i] = 1'b0; e_rst[i] = 1'b0;
         e_idx[i] = 6'd0; e_arg[i] = 32'd0;
      end
      for (int i = 1; i <= 3; i++) e_rst[i] = 1'b1;
      goto_edge(3);
      reset = 1'b0;
      chk("reset_pin_out", 64'(cmd_pin_out), 64'(1));
      chk("reset_oe", 64'(cmd_oe), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_index", 64'(cmd_index), 64'(0));
      chk("reset_argument", 64'(cmd_argument), 64'(0));
      chk("model_crc_cmd0", 64'(model_crc(40'h40_0000_0000)), 64'(7'h4A));
      chk("model_crc_cmd8", 64'(model_crc(40'h48_0000_01AA)), 64'(7'h43));
      chk("model_crc_cmd17", 64'(model_crc(40'h51_0000_0000)), 64'(7'h2A));
      chk("model_crc_r7", 64'(model_crc(40'h08_0000_01AA)), 64'(7'h09));

      // CMD0, application declines to answer
      send_cmd(48'h40_0000_0000_95, A_NONE, 0, 6'd0, 32'd0, s, ts, done);
      goto_edge(done + 2);

      // CMD8 with R7-style response
      cap = 48'd0; oe_cnt = 0; first_oe = -1; cap_en = 1'b1;
      send_cmd(48'h48_0000_01AA_87, A_STROBE, 0, 6'd8, 32'h0000_01AA, s, ts, done);
      goto_edge(done + 2);
      cap_en = 1'b0;
      chk("resp_frame", 64'(cap), 64'(48'h08_0000_01AA_13));
      chk("oe_cycles", 64'(oe_cnt), 64'(48));
      chk("start_bit_edge", 64'(first_oe - s), 64'(50));

      // CMD0 with corrupted CRC byte
      send_cmd(48'h40_0000_0000_97, A_NONE, 1, 6'd0, 32'd0, s, ts, done);
      goto_edge(done + 2);

      // transmission bit 0, then a good CMD17
      send_cmd(48'h00_0000_0000_01, A_STROBE, 0, 6'd8, 32'h1AA, s, ts, done);
      goto_edge(done + 2);
      send_cmd(48'h51_0000_0000_55, A_NONE, 3, 6'd0, 32'd0, s, ts, done);
      goto_edge(done + 2);
      chk("cmd17_index", 64'(cmd_index), 64'(17));

      // CMD17 unanswered, then a late strobe
      send_cmd(48'h51_0000_0000_55, A_STRAY, 0, 6'd17, 32'h900, s, ts, done);
      chk("timeout_edge", 64'(done - s), 64'(111));
      goto_edge(done + 3);

      // strobe and none together
      send_cmd(48'h51_0000_1234_55, A_BOTH, 2, 6'd17, 32'h900, s, ts, done);
      goto_edge(done + 2);

      // end bit 0
      send_cmd(48'h40_0000_0000_94, A_NONE, 0, 6'd0, 32'd0, s, ts, done);
      goto_edge(done + 2);

      // CMD55, late strobe
      send_cmd(48'h77_0000_0000_65, A_STROBE, 5, 6'd55, 32'h0000_0120, s, ts, done);
      goto_edge(done + 2);

      // reset in the middle of a response
      send_cmd(48'h48_0000_01AA_87, A_STROBE, 0, 6'd8, 32'h0000_01AA, s, ts, done);
      goto_edge(ts + 19);
      reset = 1'b1;
      for (int e = ts + 20; e < ARR; e++) begin
         e_pin[e] = 1'b1; e_oe[e] = 1'b0; e_busy[e] = 1'b0; e_valid[e] = 1'b0;
         e_ferr[e] = 1'b0; e_cerr[e] = 1'b0; e_tout[e] = 1'b0;
      end
      e_rst[ts + 20] = 1'b1;
      goto_edge(ts + 20);
      reset = 1'b0;
      chk("midsend_reset_oe", 64'(cmd_oe), 64'(0));
      chk("midsend_reset_pin", 64'(cmd_pin_out), 64'(1));
      chk("midsend_reset_busy", 64'(busy), 64'(0));
      goto_edge(ts + 22);
      send_cmd(48'h51_0000_0000_55, A_NONE, 0, 6'd0, 32'd0, s, ts, done);
      goto_edge(done + 2);
      chk("post_reset_index", 64'(cmd_index), 64'(17));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
